// File: rtl/bcd_counter_n.sv
// Cascaded BCD up/down counter: DIGITS decades, sync clear/load, combinational tc, sticky overflow.
// Optional macro BCD_COUNTER_SAT_EN: saturate at all-9s / all-0s instead of wrapping.
module bcd_counter_n #(
   parameter int DIGITS = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                enable,
   input  logic                up_down,
   input  logic                clear,
   input  logic                load,
   input  logic [4*DIGITS-1:0] load_value,
   output logic [4*DIGITS-1:0] out,
   output logic                tc,
   output logic                overflow
);

   logic [4*DIGITS-1:0] count_q;
   logic [4*DIGITS-1:0] count_d;
   logic [4*DIGITS-1:0] wrap_d;
   logic [4*DIGITS-1:0] load_clean;
   logic [DIGITS:0]     chain;
   logic                at_limit;

   // chain[k] is the carry/borrow into digit k; chain[DIGITS] means every digit sits at the limit
   assign chain[0] = 1'b1;

   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      logic [3:0] cur;
      logic [3:0] nxt;
      logic [3:0] ld_digit;
      logic       is_nine;
      logic       is_zero;

      assign cur      = count_q[4*g +: 4];
      assign ld_digit = load_value[4*g +: 4];
      assign is_nine  = (cur == 4'd9);
      assign is_zero  = (cur == 4'd0);

      assign chain[g+1] = chain[g] & (up_down ? is_nine : is_zero);

      always_comb begin
         nxt = cur;
         if (chain[g]) begin
            if (up_down) nxt = is_nine ? 4'd0 : cur + 4'd1;
            else         nxt = is_zero ? 4'd9 : cur - 4'd1;
         end
      end

      assign wrap_d[4*g +: 4]     = nxt;
      assign load_clean[4*g +: 4] = (ld_digit > 4'd9) ? 4'd0 : ld_digit;
   end

   assign at_limit = chain[DIGITS];
   assign tc       = enable & at_limit;

`ifdef BCD_COUNTER_SAT_EN
   assign count_d = at_limit ? count_q : wrap_d;
`else
   assign count_d = wrap_d;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q  <= '0;
         overflow <= 1'b0;
      end else if (clear) begin
         count_q  <= '0;
         overflow <= 1'b0;
      end else if (load) begin
         count_q <= load_clean;
      end else if (enable) begin
         count_q <= count_d;
         if (at_limit) overflow <= 1'b1;
      end
   end

   assign out = count_q;

endmodule

// File: tb/tb_bcd_counter_n.sv
// Scoreboard bench for bcd_counter_n: DIGITS=2,3,4 instances driven in parallel,
// expected values from an integer-arithmetic model, checked by a negedge monitor.
module tb_bcd_counter_n;

`ifdef BCD_COUNTER_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [2:0]  rn, en, ud, clr, ld;
   logic [31:0] lv [3];
   logic [2:0]  nxt_rn, nxt_en, nxt_ud, nxt_clr, nxt_ld;
   logic [31:0] nxt_lv [3];

   logic [7:0]  out2;
   logic [11:0] out3;
   logic [15:0] out4;
   logic [2:0]  tc, ovf;

   bcd_counter_n #(.DIGITS(2)) u_d2 (
      .clk(clk), .reset_n(rn[0]), .enable(en[0]), .up_down(ud[0]), .clear(clr[0]),
      .load(ld[0]), .load_value(lv[0][7:0]), .out(out2), .tc(tc[0]), .overflow(ovf[0]));
   bcd_counter_n #(.DIGITS(3)) u_d3 (
      .clk(clk), .reset_n(rn[1]), .enable(en[1]), .up_down(ud[1]), .clear(clr[1]),
      .load(ld[1]), .load_value(lv[1][11:0]), .out(out3), .tc(tc[1]), .overflow(ovf[1]));
   bcd_counter_n #(.DIGITS(4)) u_d4 (
      .clk(clk), .reset_n(rn[2]), .enable(en[2]), .up_down(ud[2]), .clear(clr[2]),
      .load(ld[2]), .load_value(lv[2][15:0]), .out(out4), .tc(tc[2]), .overflow(ovf[2]));

   typedef struct {
      int          inst;
      logic [31:0] out;
      logic        ovf;
      logic        tc;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int unsigned mv [3];
   logic        movf [3];

   function automatic int unsigned max_val(input int i);
      int unsigned p = 1;
      for (int k = 0; k < i + 2; k++) p = p * 10;
      return p - 1;
   endfunction

   function automatic int unsigned bcd_to_int(input logic [31:0] b, input int nd);
      int unsigned v = 0;
      for (int k = nd - 1; k >= 0; k--) begin
         int unsigned d = (b >> (4 * k)) & 32'hF;
         if (d > 9) d = 0;
         v = v * 10 + d;
      end
      return v;
   endfunction

   function automatic logic [31:0] int_to_bcd(input int unsigned v, input int nd);
      logic [31:0] r = '0;
      int unsigned t = v;
      for (int k = 0; k < nd; k++) begin
         r = r | ((t % 10) << (4 * k));
         t = t / 10;
      end
      return r;
   endfunction

   task automatic model_edge(input int i);
      int unsigned mx = max_val(i);
      if (!rn[i] || clr[i]) begin
         mv[i]   = 0;
         movf[i] = 1'b0;
      end else if (ld[i]) begin
         mv[i] = bcd_to_int(lv[i], i + 2);
      end else if (en[i]) begin
         if (ud[i]) begin
            if (mv[i] == mx) begin
               movf[i] = 1'b1;
               mv[i]   = SAT ? mx : 0;
            end else mv[i] = mv[i] + 1;
         end else begin
            if (mv[i] == 0) begin
               movf[i] = 1'b1;
               mv[i]   = SAT ? 0 : mx;
            end else mv[i] = mv[i] - 1;
         end
      end
   endtask

   // One clock: the edge consumes the current inputs, then the next inputs are applied.
   task automatic step();
      @(posedge clk);
      for (int i = 0; i < 3; i++) model_edge(i);
      #1;
      rn = nxt_rn; en = nxt_en; ud = nxt_ud; clr = nxt_clr; ld = nxt_ld;
      for (int i = 0; i < 3; i++) lv[i] = nxt_lv[i];
      for (int i = 0; i < 3; i++) begin
         exp_t e;
         if (!rn[i]) begin
            mv[i]   = 0;
            movf[i] = 1'b0;
         end
         e.inst = i;
         e.out  = int_to_bcd(mv[i], i + 2);
         e.ovf  = movf[i];
         e.tc   = en[i] & (ud[i] ? (mv[i] == max_val(i)) : (mv[i] == 0));
         sb.push_back(e);
      end
   endtask

   task automatic set_ctl(input int i, input logic e, input logic u, input logic c,
                          input logic l, input logic [31:0] v);
      nxt_en[i] = e; nxt_ud[i] = u; nxt_clr[i] = c; nxt_ld[i] = l; nxt_lv[i] = v;
   endtask

   always @(negedge clk) begin
      while (sb.size() > 0) begin
         exp_t        e;
         logic [31:0] got;
         e = sb.pop_front();
         case (e.inst)
            0:       got = {24'd0, out2};
            1:       got = {20'd0, out3};
            default: got = {16'd0, out4};
         endcase
         checks = checks + 3;
         if (got !== e.out) begin
            errors++;
            $display("FAIL d%0d out: got %h expected %h at %0t", e.inst + 2, got, e.out, $time);
         end
         if (ovf[e.inst] !== e.ovf) begin
            errors++;
            $display("FAIL d%0d overflow: got %b expected %b at %0t", e.inst + 2, ovf[e.inst], e.ovf, $time);
         end
         if (tc[e.inst] !== e.tc) begin
            errors++;
            $display("FAIL d%0d tc: got %b expected %b at %0t", e.inst + 2, tc[e.inst], e.tc, $time);
         end
      end
   end

   initial begin
      rn = '0; en = '0; ud = '0; clr = '0; ld = '0;
      nxt_rn = '0; nxt_en = '0; nxt_ud = '0; nxt_clr = '0; nxt_ld = '0;
      for (int i = 0; i < 3; i++) begin
         lv[i] = '0; nxt_lv[i] = '0; mv[i] = 0; movf[i] = 1'b0;
      end

      // reset held, including tc behaviour under enable/down during reset
      step();
      nxt_en = 3'b111; nxt_ud = 3'b010;
      step();
      step();
      nxt_en = '0; nxt_rn = '1;
      step();

      // 2-digit full up sweep through the wrap
      set_ctl(0, 1, 1, 0, 0, 0);
      repeat (102) step();
      set_ctl(0, 0, 1, 0, 0, 0);
      step();

      // 3-digit borrow across two decades
      set_ctl(1, 0, 0, 0, 1, 32'h100);
      step();
      set_ctl(1, 1, 0, 0, 0, 0);
      repeat (3) step();
      set_ctl(1, 0, 0, 0, 0, 0);
      step();

      // illegal load digits are zeroed
      set_ctl(2, 0, 0, 0, 1, 32'h3C7F);
      step();
      set_ctl(2, 0, 0, 0, 0, 0);
      step();

      // set overflow, then clear wins over load and enable
      set_ctl(2, 0, 1, 0, 1, 32'h9999);
      step();
      set_ctl(2, 1, 1, 0, 0, 0);
      repeat (2) step();
      set_ctl(2, 0, 1, 0, 1, 32'h0042);
      step();
      set_ctl(2, 1, 1, 1, 1, 32'h1234);
      step();
      set_ctl(2, 0, 1, 0, 0, 0);
      step();
      step();

      // async reset asserted between edges while counting in the 0x005x range
      set_ctl(2, 0, 1, 0, 1, 32'h0050);
      step();
      set_ctl(2, 1, 1, 0, 0, 0);
      repeat (7) step();
      nxt_rn[2] = 1'b0;
      step();
      nxt_rn[2] = 1'b1;
      set_ctl(2, 1, 1, 0, 0, 0);
      repeat (3) step();

      // limit behaviour at both ends (saturating or wrapping depending on build)
      set_ctl(0, 0, 1, 1, 0, 0);
      step();
      set_ctl(0, 0, 1, 0, 1, 32'h99);
      step();
      set_ctl(0, 1, 1, 0, 0, 0);
      repeat (3) step();
      set_ctl(0, 0, 0, 0, 1, 32'h00);
      step();
      set_ctl(0, 1, 0, 0, 0, 0);
      repeat (3) step();

      // randomized traffic on all three instances, direction flips every cycle allowed
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < 3; i++) begin
            logic [31:0] v;
            case ($urandom % 4)
               0:       v = 32'h99999999;
               1:       v = 32'h0;
               2:       v = $urandom;
               default: v = 32'h1;
            endcase
            set_ctl(i, ($urandom % 4) != 0, $urandom % 2 == 1, ($urandom % 25) == 0,
                    ($urandom % 12) == 0, v);
            nxt_rn[i] = ($urandom % 60) != 0;
         end
         step();
      end

      nxt_rn = '1;
      for (int i = 0; i < 3; i++) set_ctl(i, 0, 0, 0, 0, 0);
      step();
      @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard drain: got %0d pending expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bcd_counter_n.md
BCD_COUNTER_N -- requirements
Module: bcd_counter_n

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4, meaning the number of cascaded BCD digits (legal range 1..8).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port enable, input, 1 bit: count enable.
REQ-005 The block SHALL have port up_down, input, 1 bit: count direction, 1 = up, 0 = down.
REQ-006 The block SHALL have port clear, input, 1 bit: synchronous clear to zero.
REQ-007 The block SHALL have port load, input, 1 bit: synchronous parallel load.
REQ-008 The block SHALL have port load_value, input, 4*DIGITS bits: packed BCD load data; digit 0 in bits [3:0].
REQ-009 The block SHALL have port out, output, 4*DIGITS bits: packed BCD count; digit 0 in bits [3:0].
REQ-010 The block SHALL have port tc, output, 1 bit: terminal count, used for cascading.
REQ-011 The block SHALL have port overflow, output, 1 bit: sticky wrap or saturation flag.

Function
REQ-012 The block SHALL apply control priority per rising edge in this order: clear, then load, then enable-count, then hold.
REQ-013 The block SHALL, on clear, set out to all zeros and overflow to 0.
REQ-014 The block SHALL, on load, write load_value to out with one-cycle latency.
REQ-015 The block SHALL, during load, replace any load_value digit in 4'hA..4'hF with 4'h0, so every out digit is always in 0..9.
REQ-016 The block SHALL, when counting up, increment digit 0 and pass a carry to digit k+1 only when digits 0..k are all 9.
REQ-017 The block SHALL, when counting up, set a digit that receives a carry while at 9 to 0.
REQ-018 The block SHALL, when counting down, decrement digit 0 and pass a borrow to digit k+1 only when digits 0..k are all 0.
REQ-019 The block SHALL, when counting down, set a digit that receives a borrow while at 0 to 9.
REQ-020 The block SHALL drive tc combinationally as enable AND (up_down ? all digits == 9 : all digits == 0); clear and load do not gate it.
REQ-021 The block SHALL, with wrap enabled, go from all-9s to all-0s on an up count and from all-0s to all-9s on a down count.
REQ-022 The block SHALL set overflow to 1 on any edge where a count occurs while tc = 1, and hold it at 1 until clear or reset.
REQ-023 The block SHALL let up_down change on any cycle; the new direction applies on the next counting edge with no dead cycle.
REQ-024 The block SHALL hold out and overflow unchanged when enable = 0, clear = 0 and load = 0.

Reset
REQ-025 The block SHALL, while reset_n = 0, immediately force out to all zeros and overflow to 0, independent of clk.
REQ-026 The block SHALL drive tc from the reset value during reset: 1 if enable = 1 and up_down = 0, else 0.
REQ-027 The block SHALL resume counting on the first rising clk edge after reset_n deasserts, and a count in progress when reset asserts SHALL be discarded.

Configuration
REQ-028 The block SHALL recognise the macro BCD_COUNTER_SAT_EN.
REQ-029 The block SHALL, with BCD_COUNTER_SAT_EN defined, saturate instead of wrapping: an up count at all-9s holds all-9s, and a down count at all-0s holds all-0s.
REQ-030 The block SHALL, with BCD_COUNTER_SAT_EN defined, still drive tc per REQ-020 and still set overflow per REQ-022 on a saturated count attempt.
REQ-031 The block SHALL, with BCD_COUNTER_SAT_EN undefined, wrap per REQ-021.

Verification
REQ-032 The bench SHALL cover: DIGITS=2, reset, enable=1, up=1 for 100 edges -> out steps 00..99 then 00; tc high at 99; overflow=1 after the wrap.
REQ-033 The bench SHALL cover: DIGITS=3, load 0x100, down count 1 edge -> out=0x099; one more edge -> 0x098; tc=0 throughout.
REQ-034 The bench SHALL cover: load_value=0x3C7F with DIGITS=4 -> out=0x3070 on the next edge.
REQ-035 The bench SHALL cover: clear=1, load=1, enable=1 on the same edge with out=0x0042 -> out=0x0000 and overflow=0.
REQ-036 The bench SHALL cover: reset_n pulsed low mid-cycle while counting at 0x0057 -> out=0x0000 before the next clk edge.
REQ-037 The bench SHALL cover: with BCD_COUNTER_SAT_EN defined, DIGITS=2 at 99, up count 3 edges -> out stays 99, overflow=1; down from 00 -> stays 00.
